// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: state encoding, default sizing and latency-counter helpers for mem_responder
package mem_resp_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_READ_LATENCY = 2;
  localparam int CNT_W            = 4;
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic cnt_t lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction
endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: single-port word store with registered read port; the store itself is never reset
module mem_resp_array #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic          i_clr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_rdata <= '0;
    else if (i_clr) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder with four-phase READY handshake.
// Define MEM_RESP_ERR_EN to add the ERR port (out-of-range address and READ+WRITE collision faults).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_ready
`ifdef MEM_RESP_ERR_EN
  ,
  output logic                  o_err
`endif
);
  logic [1:0]            r_state;
  cnt_t                  r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wr;
  logic                  r_ready;
  logic                  w_req;
  logic                  w_done;
  logic                  w_bad;
  logic                  w_err_req;
  assign w_req  = i_read | i_write;
  assign w_done = (r_state == ST_BUSY) && w_req && (r_cnt == '0);
`ifdef MEM_RESP_ERR_EN
  logic r_bad;
  logic r_err;
  assign w_bad     = r_bad;
  assign w_err_req = i_read & i_write;
  assign o_err     = r_err;
  // r_bad is only consumed after acceptance, so it may track the bus freely while idle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_bad <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_bad <= |i_addr[31:ADDR_WIDTH];
      r_err <= (r_state == ST_IDLE) ? w_err_req :
               (r_state == ST_BUSY) ? (w_done & r_bad) : (r_err & w_req);
    end
`else
  logic w_unused_hi;
  assign w_unused_hi = |i_addr[31:ADDR_WIDTH];
  assign w_bad       = 1'b0;
  assign w_err_req   = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) begin
          r_state <= w_err_req ? ST_ACK : ST_BUSY;
          r_ready <= w_err_req;
          r_cnt   <= lat_load(READ_LATENCY);
          r_addr  <= i_addr[ADDR_WIDTH-1:0];
          r_wdata <= i_data_in;
          r_wr    <= i_write & ~i_read;
        end
        ST_BUSY: if (!w_req) r_state <= ST_IDLE;
          else if (r_cnt == '0) begin
            r_state <= ST_ACK;
            r_ready <= 1'b1;
          end else r_cnt <= r_cnt - 1'b1;
        ST_ACK: if (!w_req) begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  mem_resp_array #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_array (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_done & r_wr & ~w_bad),
    .i_re    (w_done & ~r_wr & ~w_bad),
    .i_clr   (w_done & w_bad),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (o_data_out)
  );
  assign o_ready = r_ready;
endmodule
